// File: rtl/spi_target.sv
// SPI Mode-0 target port bridging an external SPI master to the Z80 I/O bus.
// Received bytes land in a 4-entry RX FIFO; the CPU preloads one TX byte.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   cep               CPU-side clock enable qualifying bus strobes
//   iorq, wr, rd      Z80 bus strobes, active low
//   a, d              Z80 low address byte, CPU write data
//   q                 CPU read data (combinational)
//   ss, sck, mosi     SPI inputs from the master (asynchronous)
//   miso              SPI data to the master (registered)
module spi_target #(
    parameter logic [7:0] DATA_PORT = 8'h3B,
    parameter logic [7:0] STAT_PORT = 8'h3F,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cep,
    input  logic       iorq,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers: [0],[1] form the 2-flop synchroniser, [2] is the
    // delayed copy used for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] ss_sync;
    logic [2:0] sck_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            ss_sync   <= 3'b111;
            sck_sync  <= 3'b000;
            mosi_sync <= 2'b11;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss};
            sck_sync  <= {sck_sync[1:0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    logic ss_fall;
    logic ss_rise;
    logic sck_rise;
    logic sck_fall;
    logic mosi_s;
    logic ss_active;

    assign ss_fall   = ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sck_rise  = ~sck_sync[2] & sck_sync[1];
    assign sck_fall  = sck_sync[2] & ~sck_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ss_active = ~ss_sync[1];

    // ------------------------------------------------------------------
    // CPU bus decode: one pulse per strobe assertion, on a cep cycle.
    // ------------------------------------------------------------------
    logic hit_data;
    logic hit_stat;
    logic strobe;
    logic strobe_q;
    logic pulse;
    logic wr_pulse;
    logic rd_pulse;
    logic st_pulse;

    assign hit_data = (a == DATA_PORT);
    assign hit_stat = (a == STAT_PORT);
    assign strobe   = !iorq && (!wr || !rd) && (hit_data || hit_stat);
    assign pulse    = cep && strobe && !strobe_q;
    assign wr_pulse = pulse && !wr && hit_data;
    assign rd_pulse = pulse && !rd && hit_data;
    assign st_pulse = pulse && !rd && hit_stat;

    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else if (cep) begin
            strobe_q <= strobe;
        end
    end

    // ------------------------------------------------------------------
    // Shared SPI / FIFO / TX-holding signals
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;

    logic [7:0] fifo [4];
    logic [1:0] wp;
    logic [1:0] rp;
    logic [2:0] cnt;
    logic       overrun;

    logic [7:0] tx_hold;
    logic       tx_empty;

    logic       in_shift;
    logic       load_tx;
    logic       byte_done;
    logic [7:0] tx_next;
    logic [7:0] rx_byte;
    logic       rx_avail;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    assign in_shift  = (state == S_SHIFT);
    assign tx_next   = tx_empty ? IDLE_BYTE : tx_hold;
    assign rx_byte   = {rx_sh[6:0], mosi_s};

    // A TX byte is fetched at frame start and after every completed byte.
    assign load_tx   = (!in_shift && ss_fall)
                     || (in_shift && !ss_rise && sck_fall
                         && (bit_cnt == 3'd0));

    assign byte_done = in_shift && !ss_rise && sck_rise
                     && (bit_cnt == 3'd7);

    assign rx_avail  = (cnt != 3'd0);
    assign full      = (cnt == 3'd4);
    assign pop       = rd_pulse && rx_avail;

    // A pop in the same clock frees the slot, so a full FIFO still accepts.
    assign push      = byte_done && (!full || pop);
    assign drop      = byte_done && full && !pop;

    // ------------------------------------------------------------------
    // SPI shift state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            tx_sh   <= 8'hFF;
            rx_sh   <= 8'hFF;
            miso    <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    miso    <= 1'b1;
                    bit_cnt <= 3'd0;
                    if (ss_fall) begin
                        state <= S_SHIFT;
                        tx_sh <= tx_next;
                        miso  <= tx_next[7];
                    end
                end
                S_SHIFT: begin
                    if (ss_rise) begin
                        // Partial RX byte and any loaded TX byte are lost.
                        state   <= S_IDLE;
                        miso    <= 1'b1;
                        bit_cnt <= 3'd0;
                        rx_sh   <= 8'hFF;
                    end else if (sck_rise) begin
                        rx_sh   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (sck_fall) begin
                        if (bit_cnt != 3'd0) begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                            miso  <= tx_sh[6];
                        end else begin
                            tx_sh <= tx_next;
                            miso  <= tx_next[7];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO storage (data needs no reset; count/pointers qualify it)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wp] <= rx_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp      <= 2'd0;
            rp      <= 2'd0;
            cnt     <= 3'd0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 2'd1;
            end
            if (pop) begin
                rp <= rp + 2'd1;
            end
            cnt <= cnt + {2'b00, push} - {2'b00, pop};
            // Set takes priority over a same-cycle status-read clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (st_pulse) begin
                overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_hold  <= 8'hFF;
            tx_empty <= 1'b1;
        end else if (wr_pulse) begin
            // A same-cycle load consumed the old value; the new one stays.
            tx_hold  <= d;
            tx_empty <= 1'b0;
        end else if (load_tx && !tx_empty) begin
            tx_empty <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // CPU read data
    // ------------------------------------------------------------------
    always_comb begin
        q = 8'hFF;
        unique case (1'b1)
            hit_stat: q = {4'b0000, ss_active, overrun, tx_empty, rx_avail};
            hit_data: q = rx_avail ? fifo[rp] : 8'hFF;
            default:  q = 8'hFF;
        endcase
    end

endmodule
